// File: rtl/core_pkg.sv
// Shared definitions for the execute/memory slice: LSU state encoding and RV32 load/store size codes.
package core_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } lsu_state_t;

  localparam logic [2:0] F3_B = 3'b000;
  localparam logic [2:0] F3_H = 3'b001;
  localparam logic [2:0] F3_W = 3'b010;

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane alignment for the LSU: store data shifted up to its lane, load data shifted down to bit 0,
// plus the natural-alignment check for halfword and word accesses.
module lsu_lane_align
  import core_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  input  logic [31:0] store_data,
  input  logic [31:0] load_data,
  output logic [31:0] store_shifted,
  output logic [31:0] load_shifted,
  output logic        misaligned
);

  logic unused_sign;

  // Sign/zero extension is the writeback stage's job, so funct3[2] plays no part here.
  assign unused_sign = funct3[2];

  assign store_shifted = store_data << {addr_lo, 3'b000};
  assign load_shifted  = load_data >> {addr_lo, 3'b000};

  assign misaligned = ((funct3[1:0] == F3_H[1:0]) & addr_lo[0]) |
                      ((funct3[1:0] == F3_W[1:0]) & (addr_lo != 2'b00));

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store sequencer between execute datapath B and the handshaked data bus: one access at a time,
// pipeline stall while busy, lane alignment, misalign detection, flush handling and a bus timeout.
module lsu_mem_ctrl
  import core_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_re,
  input  logic [3:0]  req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  input  logic        flush,
  output logic        stall,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        misalign,
  output logic        bus_err,
  output logic        mem_req,
  output logic [3:0]  mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam logic [15:0] LAST_COUNT = 16'(TIMEOUT_CYCLES - 1);

  lsu_state_t  state_q, state_d;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [3:0]  we_q;
  logic [2:0]  funct3_q;
  logic [15:0] count_q;
  logic        kill_q, err_q;

  logic        in_idle, req_present, misaligned, accept, is_store, killed;
  logic        timeout_hit, timeout_done;
  logic [1:0]  align_addr;
  logic [2:0]  align_funct3;
  logic [31:0] store_shifted, load_shifted;

  assign in_idle     = (state_q == IDLE);
  assign req_present = req_re | (|req_we);

  // The aligner sees the live request while idle and the latched operation once it is in flight.
  assign align_addr   = in_idle ? req_addr[1:0] : addr_q[1:0];
  assign align_funct3 = in_idle ? req_funct3 : funct3_q;

  lsu_lane_align u_align (
    .addr_lo      (align_addr),
    .funct3       (align_funct3),
    .store_data   (req_wdata),
    .load_data    (mem_rdata),
    .store_shifted(store_shifted),
    .load_shifted (load_shifted),
    .misaligned   (misaligned)
  );

  assign accept      = in_idle & req_present & ~misaligned & ~flush;
  assign is_store    = |we_q;
  assign killed      = kill_q | flush;
  assign timeout_hit = (count_q == LAST_COUNT);
  assign timeout_done = timeout_hit &
                        (((state_q == REQ)  & ~mem_gnt    & ~flush) |
                         ((state_q == WAIT) & ~mem_rvalid & ~killed));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = REQ;
      REQ: begin
        if (mem_gnt)          state_d = is_store ? (flush ? IDLE : DONE) : WAIT;
        else if (flush)       state_d = IDLE;
        else if (timeout_hit) state_d = DONE;
      end
      WAIT: begin
        if (mem_rvalid || timeout_hit) state_d = killed ? IDLE : DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      we_q     <= '0;
      funct3_q <= '0;
      count_q  <= '0;
      kill_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          kill_q <= 1'b0;
          if (accept) begin
            addr_q   <= req_addr;
            wdata_q  <= store_shifted;
            we_q     <= req_we;
            funct3_q <= req_funct3;
            count_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
          end
        end
        REQ: begin
          count_q <= count_q + 16'd1;
          // A flushed load that was already granted must still drain its read data.
          if (mem_gnt && flush && !is_store) kill_q <= 1'b1;
          if (timeout_done) err_q <= 1'b1;
        end
        WAIT: begin
          count_q <= count_q + 16'd1;
          if (flush) kill_q <= 1'b1;
          if (mem_rvalid) rdata_q <= load_shifted;
          if (timeout_done) err_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign stall      = accept | (state_q == REQ) | (state_q == WAIT);
  assign misalign   = in_idle & req_present & misaligned & ~flush;
  assign resp_valid = (state_q == DONE);
  assign bus_err    = (state_q == DONE) & err_q;
  assign resp_rdata = rdata_q;
  assign mem_req    = (state_q == REQ);
  assign mem_we     = (state_q == REQ) ? we_q : 4'b0000;
  assign mem_addr   = {addr_q[31:2], 2'b00};
  assign mem_wdata  = wdata_q;

endmodule
